// File: rtl/rgb_wheel_sequencer.sv
// RGB LED colour-wheel sequencer: six-segment fade/step with
// brightness-scaled, frame-latched PWM on active-low pins.
module rgb_wheel_sequencer #(
  parameter int LEVEL_CYCLES = 7812,
  parameter int PWM_BITS     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clear,
  input  logic       mode,
  input  logic [7:0] bright,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic [2:0] phase,
  output logic [7:0] level,
  output logic       wrap
);

  localparam int P  = PWM_BITS;
  localparam int DW =
    (LEVEL_CYCLES > 1) ? $clog2(LEVEL_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(LEVEL_CYCLES - 1);
  localparam logic [2:0] PH_LAST = 3'd5;

  logic [DW-1:0] div_q, div_d;
  logic [P-1:0]  level_q, level_d;
  logic [2:0]    phase_q, phase_d;
  logic          wrap_q, wrap_d;

  logic [P-1:0]         pwm_q;
  logic [2:0][P-1:0]    duty_q;
  logic [2:0][P-1:0]    raw;
  logic [2:0][P-1:0]    eff;
  logic [2:0]           lit;
  logic [2:0]           pin_q;

  logic [P-1:0] lv;
  logic [P-1:0] lv_n;
  logic         div_end;
  logic         frame_end;

  function automatic logic [P-1:0] scale(
    input logic [P-1:0] r,
    input logic [P-1:0] b
  );
    logic [2*P-1:0] prod;
    prod = {{P{1'b0}}, r} *
           ({{P{1'b0}}, b} + (2*P)'(1));
    return prod[2*P-1:P];
  endfunction

  assign div_end   = (div_q == DIV_LAST);
  assign frame_end = (pwm_q == '1);

  always_comb begin
    div_d   = div_q;
    level_d = level_q;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    if (clear) begin
      div_d   = '0;
      level_d = '0;
      phase_d = '0;
    end else if (en) begin
      if (div_end) begin
        div_d   = '0;
        level_d = level_q + 1'b1;
        if (level_q == '1) begin
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            wrap_d  = 1'b1;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      level_q <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      level_q <= level_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
    end
  end

  // Hard-step mode pins the ramp at zero, leaving solid colours.
  assign lv   = mode ? '0 : level_q;
  assign lv_n = ~lv;

  always_comb begin
    raw = '0;
    unique case (phase_q)
      3'd0: raw = {{P{1'b0}}, lv, {P{1'b1}}};
      3'd1: raw = {{P{1'b0}}, {P{1'b1}}, lv_n};
      3'd2: raw = {lv, {P{1'b1}}, {P{1'b0}}};
      3'd3: raw = {{P{1'b1}}, lv_n, {P{1'b0}}};
      3'd4: raw = {{P{1'b1}}, {P{1'b0}}, lv};
      3'd5: raw = {lv_n, {P{1'b0}}, {P{1'b1}}};
      default: raw = '0;
    endcase
  end

  always_comb begin
    eff = '0;
    lit = '0;
    for (int i = 0; i < 3; i++) begin
      eff[i] = scale(raw[i], bright);
      lit[i] = (duty_q[i] == '1) ||
               (pwm_q < duty_q[i]);
    end
  end

  // Duties only change at the frame boundary to avoid PWM glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q  <= '0;
      duty_q <= '0;
      pin_q  <= '1;
    end else begin
      pwm_q <= pwm_q + 1'b1;
      pin_q <= ~lit;
      if (frame_end) begin
        duty_q <= eff;
      end
    end
  end

  assign RGB_R = pin_q[0];
  assign RGB_G = pin_q[1];
  assign RGB_B = pin_q[2];
  assign phase = phase_q;
  assign level = level_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_rgb_wheel_sequencer.sv
// Self-checking bench for rgb_wheel_sequencer against an
// arithmetic model of wheel position and PWM frames.
module tb_rgb_wheel_sequencer;

  localparam int LC    = 2;
  localparam int WHEEL = LC * 256 * 6;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic       mode;
  logic [7:0] bright;
  logic       RGB_R;
  logic       RGB_G;
  logic       RGB_B;
  logic [2:0] phase;
  logic [7:0] level;
  logic       wrap;

  int n_chk;
  int n_err;

  int m_adv;
  int m_wrap;
  int m_pwm;
  int m_duty [3];
  int m_pin  [3];

  rgb_wheel_sequencer #(
    .LEVEL_CYCLES(LC),
    .PWM_BITS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .clear(clear),
    .mode(mode),
    .bright(bright),
    .RGB_R(RGB_R),
    .RGB_G(RGB_G),
    .RGB_B(RGB_B),
    .phase(phase),
    .level(level),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input int          exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int phase_of(input int a);
    return a / (LC * 256);
  endfunction

  function automatic int level_of(input int a);
    return (a / LC) % 256;
  endfunction

  // Colour-wheel table: channel 0=R, 1=G, 2=B
  function automatic int raw_duty(
    input int ph, input int lv,
    input int md, input int ch
  );
    int l;
    int t [6][3];
    l = md ? 0 : lv;
    t[0] = '{255, l, 0};
    t[1] = '{255 - l, 255, 0};
    t[2] = '{0, 255, l};
    t[3] = '{0, 255 - l, 255};
    t[4] = '{l, 0, 255};
    t[5] = '{255, 0, 255 - l};
    return t[ph][ch];
  endfunction

  function automatic int eff(input int r, input int b);
    return (r * (b + 1)) >> 8;
  endfunction

  task automatic model_reset();
    m_adv  = 0;
    m_wrap = 0;
    m_pwm  = 0;
    for (int i = 0; i < 3; i++) begin
      m_duty[i] = 0;
      m_pin[i]  = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m_pin[i] = ((m_duty[i] == 255) ||
                  (m_pwm < m_duty[i])) ? 0 : 1;
    end
    if (m_pwm == 255) begin
      for (int i = 0; i < 3; i++) begin
        m_duty[i] = eff(raw_duty(phase_of(m_adv),
                                 level_of(m_adv),
                                 int'(mode), i),
                        int'(bright));
      end
    end
    m_pwm = (m_pwm + 1) % 256;
    if (clear) begin
      m_adv  = 0;
      m_wrap = 0;
    end else if (en) begin
      m_adv  = (m_adv + 1) % WHEEL;
      m_wrap = (m_adv == 0) ? 1 : 0;
    end else begin
      m_wrap = 0;
    end
    @(negedge clk);
    chk("phase", 32'(phase), phase_of(m_adv));
    chk("level", 32'(level), level_of(m_adv));
    chk("wrap", 32'(wrap), m_wrap);
    chk("pins", 32'({RGB_B, RGB_G, RGB_R}),
        m_pin[2] * 4 + m_pin[1] * 2 + m_pin[0]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pins", 32'({RGB_B, RGB_G, RGB_R}), 7);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_wrap", 32'(wrap), 0);
    rst_n = 1'b1;
  endtask

  task automatic count_low(
    output int r, output int g, output int b
  );
    r = 0;
    g = 0;
    b = 0;
    repeat (256) begin
      tick();
      if (!RGB_R) r++;
      if (!RGB_G) g++;
      if (!RGB_B) b++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    int cr;
    int cg;
    int cb;
    int len;
    n_chk  = 0;
    n_err  = 0;
    en     = 1'b1;
    clear  = 1'b0;
    mode   = 1'b1;
    bright = 8'd255;
    rst_n  = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("async_pins", 32'({RGB_B, RGB_G, RGB_R}), 7);
    @(negedge clk);
    do_reset();

    // hard step, full bright: first frame dark, then red
    repeat (260) tick();
    chk("red", 32'({RGB_B, RGB_G, RGB_R}), 6);

    // one full wheel from reset: exactly one wrap pulse
    do_reset();
    nw = 0;
    repeat (WHEEL) begin
      tick();
      if (wrap) nw++;
    end
    chk("wrap_cnt", 32'(nw), 1);
    chk("wheel_ph", 32'(phase), 0);

    // smooth fade, phase 0 level 128
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mode  = 1'b0;
    repeat (128 * LC) tick();
    en = 1'b0;
    repeat (512) tick();
    count_low(cr, cg, cb);
    chk("f128_r", 32'(cr), 256);
    chk("f128_g", 32'(cg), 128);
    chk("f128_b", 32'(cb), 0);

    // level 255 at bright 127
    clear = 1'b1;
    tick();
    clear  = 1'b0;
    en     = 1'b1;
    bright = 8'd127;
    repeat (255 * LC) tick();
    en = 1'b0;
    repeat (512) tick();
    count_low(cr, cg, cb);
    chk("b127_r", 32'(cr), 127);
    chk("b127_g", 32'(cg), 127);
    chk("b127_b", 32'(cb), 0);

    // long hold with en low, then clear with en
    repeat (10000) tick();
    chk("hold_lv", 32'(level), 255);
    en    = 1'b1;
    clear = 1'b1;
    tick();
    chk("clr_ph", 32'(phase), 0);
    chk("clr_lv", 32'(level), 0);
    clear = 1'b0;

    // randomized segments
    for (int s = 0; s < 40; s++) begin
      len    = $urandom_range(600, 1);
      en     = ($urandom % 10) < 8;
      mode   = $urandom % 2;
      bright = 8'($urandom);
      repeat (len) begin
        clear = ($urandom % 250) == 0;
        tick();
      end
      clear = 1'b0;
    end

    // async reset mid-frame while red is lit
    en     = 1'b1;
    mode   = 1'b1;
    bright = 8'd255;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
    repeat (300) tick();
    while (m_pwm != 100) tick();
    chk("pre_r", 32'(RGB_R), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_r", 32'(RGB_R), 1);
    chk("arst_gb", 32'({RGB_B, RGB_G}), 3);
    model_reset();
    @(negedge clk);
    do_reset();
    count_low(cr, cg, cb);
    chk("dark_r", 32'(cr), 0);
    chk("dark_gb", 32'(cg + cb), 0);
    chk("post_ph", 32'(phase), 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
